// File: rtl/tc_timer.sv
// Programmable down-counter timer with one-shot and auto-reload modes.
// Exposes CTRL, PRESET and COUNT registers on a simple bus and raises a maskable interrupt.
module tc_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt,
    StInt
  } state_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;
  localparam logic [1:0] ModeReload = 2'b01;

  state_e      state_q;
  logic        enable_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_pend_q;

  logic        ctrl_we;
  logic        preset_we;

  assign ctrl_we   = WE && (Addr == AddrCtrl);
  assign preset_we = WE && (Addr == AddrPreset);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      enable_q   <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_pend_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable_q) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!enable_q) begin
            state_q <= StIdle;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            // PRESET of 0 lands here too, so the count never wraps
            count_q    <= 32'd0;
            state_q    <= StInt;
            irq_pend_q <= 1'b1;
          end
        end
        StInt: begin
          state_q <= StIdle;
          if (mode_q == ModeReload) begin
            irq_pend_q <= 1'b0;
          end else begin
            enable_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Bus writes come last so they override FSM updates on the same edge
      if (ctrl_we) begin
        enable_q <= Din[0];
        mode_q   <= Din[2:1];
        im_q     <= Din[3];
      end
      if (preset_we) begin
        preset_q <= Din;
      end
      if (ctrl_we || preset_we) begin
        irq_pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      AddrCtrl:   Dout = {28'd0, im_q, mode_q, enable_q};
      AddrPreset: Dout = preset_q;
      AddrCount:  Dout = count_q;
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_pend_q & im_q;

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: per-cycle expectations are queued, then popped and compared.
module tb_tc_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [1:0]  addr;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  tc_timer dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic push(input string tag, input logic [1:0] a, input logic [31:0] d,
                      input logic i);
    exp_t e;
    e.tag  = tag;
    e.addr = a;
    e.dout = d;
    e.irq  = i;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty: observed=empty expected=entry");
      return;
    end
    e    = sb.pop_front();
    Addr = e.addr;
    #1;
    checks++;
    assert (Dout === e.dout)
    else begin
      failures++;
      $error("FAIL %s dout: observed=%h expected=%h", e.tag, Dout, e.dout);
    end
    checks++;
    assert (IRQ === e.irq)
    else begin
      failures++;
      $error("FAIL %s irq: observed=%b expected=%b", e.tag, IRQ, e.irq);
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] a, input logic [31:0] d,
                     input logic i);
    push(tag, a, d, i);
    pop_check();
  endtask

  // First entry is checked now, each following entry one clock later
  task automatic run_sb();
    pop_check();
    while (sb.size() > 0) begin
      tick();
      pop_check();
    end
  endtask

  initial begin
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = 2'd0;
    Din   = 32'd0;

    // Reset state, with and without a clock edge
    #2;
    chk("rst_ctrl", 2'd0, 32'd0, 1'b0);
    chk("rst_preset", 2'd1, 32'd0, 1'b0);
    chk("rst_count", 2'd2, 32'd0, 1'b0);
    chk("rst_addr3", 2'd3, 32'd0, 1'b0);
    tick();
    chk("rst_edge_count", 2'd2, 32'd0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_ctrl", 2'd0, 32'd0, 1'b0);
    chk("post_rst_count", 2'd2, 32'd0, 1'b0);

    // One-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    push("os_n0", 2'd2, 32'd0, 1'b0);
    push("os_n1", 2'd2, 32'd0, 1'b0);
    push("os_n2", 2'd2, 32'd5, 1'b0);
    push("os_n3", 2'd2, 32'd4, 1'b0);
    push("os_n4", 2'd2, 32'd3, 1'b0);
    push("os_n5", 2'd2, 32'd2, 1'b0);
    push("os_n6", 2'd2, 32'd1, 1'b0);
    push("os_n7", 2'd2, 32'd0, 1'b1);
    push("os_n8_ctrl", 2'd0, 32'h8, 1'b1);
    push("os_n9", 2'd2, 32'd0, 1'b1);
    run_sb();

    // Acknowledge via CTRL write, no restart
    wr(2'd0, 32'h8);
    chk("ack_ctrl", 2'd0, 32'h8, 1'b0);
    tick();
    tick();
    tick();
    chk("ack_norestart", 2'd2, 32'd0, 1'b0);

    // Auto-reload, PRESET=3: period of 6
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    push("ar_n0", 2'd2, 32'd0, 1'b0);
    push("ar_n1", 2'd2, 32'd0, 1'b0);
    push("ar_n2", 2'd2, 32'd3, 1'b0);
    push("ar_n3", 2'd2, 32'd2, 1'b0);
    push("ar_n4", 2'd2, 32'd1, 1'b0);
    push("ar_n5", 2'd2, 32'd0, 1'b1);
    push("ar_n6", 2'd2, 32'd0, 1'b0);
    push("ar_n7", 2'd2, 32'd0, 1'b0);
    push("ar_n8", 2'd2, 32'd3, 1'b0);
    push("ar_n9", 2'd2, 32'd2, 1'b0);
    push("ar_n10", 2'd2, 32'd1, 1'b0);
    push("ar_n11", 2'd2, 32'd0, 1'b1);
    push("ar_n12", 2'd2, 32'd0, 1'b0);
    push("ar_n13_ctrl", 2'd0, 32'hB, 1'b0);
    run_sb();

    // Disable lands on the LOAD edge: load completes, then the FSM idles
    wr(2'd0, 32'h0);
    push("ld_dis_n0", 2'd2, 32'd3, 1'b0);
    push("ld_dis_n1", 2'd2, 32'd3, 1'b0);
    push("ld_dis_n2", 2'd2, 32'd3, 1'b0);
    run_sb();

    // Masked interrupt, then CTRL write clears the pend
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    push("mask_n0", 2'd2, 32'd3, 1'b0);
    push("mask_n1", 2'd2, 32'd3, 1'b0);
    push("mask_n2", 2'd2, 32'd2, 1'b0);
    push("mask_n3", 2'd2, 32'd1, 1'b0);
    push("mask_n4", 2'd2, 32'd0, 1'b0);
    push("mask_n5_ctrl", 2'd0, 32'h0, 1'b0);
    run_sb();
    wr(2'd0, 32'h8);
    chk("mask_unmask", 2'd0, 32'h8, 1'b0);

    // PRESET=0 behaves as 1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    push("p0_n0", 2'd2, 32'd0, 1'b0);
    push("p0_n1", 2'd2, 32'd0, 1'b0);
    push("p0_n2", 2'd2, 32'd0, 1'b0);
    push("p0_n3", 2'd2, 32'd0, 1'b1);
    push("p0_n4_ctrl", 2'd0, 32'h8, 1'b1);
    run_sb();

    // Writes to COUNT and the unused slot are ignored and do not acknowledge
    wr(2'd2, 32'h1234);
    chk("wr_count_ign", 2'd2, 32'd0, 1'b1);
    wr(2'd3, 32'hF);
    chk("wr_addr3_ctrl", 2'd0, 32'h8, 1'b1);
    chk("wr_addr3_rd", 2'd3, 32'd0, 1'b1);
    wr(2'd0, 32'h8);
    chk("p0_ack", 2'd0, 32'h8, 1'b0);

    // Reset pulse mid-count at COUNT=0x10
    wr(2'd1, 32'h20);
    wr(2'd0, 32'h9);
    repeat (18) tick();
    chk("mid_count", 2'd2, 32'h10, 1'b0);
    chk("mid_addr3", 2'd3, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ctrl", 2'd0, 32'd0, 1'b0);
    chk("mid_rst_preset", 2'd1, 32'd0, 1'b0);
    chk("mid_rst_count", 2'd2, 32'd0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_idle_count", 2'd2, 32'd0, 1'b0);
    chk("mid_idle_ctrl", 2'd0, 32'd0, 1'b0);

    // Disable takes effect on the edge where COUNT becomes 7, so 7 is held
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    repeat (4) tick();
    chk("dis_cnt8", 2'd2, 32'd8, 1'b0);
    wr(2'd0, 32'h0);
    push("dis_n0", 2'd2, 32'd7, 1'b0);
    push("dis_n1", 2'd2, 32'd7, 1'b0);
    push("dis_n2", 2'd2, 32'd7, 1'b0);
    push("dis_ctrl", 2'd0, 32'd0, 1'b0);
    run_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tc_timer.md
TC_TIMER -- requirements
Module: tc_timer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-004 Addr  input  2  register select, taken from bus address bits [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
REQ-005 WE  input  1  bus write strobe, already qualified by the bridge as targeting this device.
REQ-006 Din  input  32  bus write data.
REQ-007 Dout  output  32  read data for the selected register.
REQ-008 IRQ  output  1  interrupt request, wired to one HWInt bit of the CPU's cp0.

Function
REQ-009 CTRL SHALL hold bit0 Enable, bits[2:1] Mode (00 one-shot, 01 auto-reload, 10/11 treated as 00) and bit3 IM (interrupt mask); bits[31:4] SHALL read 0.
REQ-010 A write with WE=1 SHALL update the addressed register on the same edge: Addr 0 loads CTRL from Din[3:0], Addr 1 loads PRESET from Din, and Addr 2 or 3 is ignored.
REQ-011 Dout SHALL be combinational from Addr: CTRL (zero-extended), PRESET, or COUNT; Addr 3 SHALL return 0.
REQ-012 The FSM SHALL have four states: IDLE, LOAD, CNT and INT.
REQ-013 IDLE: if Enable=1 the FSM SHALL go to LOAD; otherwise it SHALL stay in IDLE.
REQ-014 LOAD: the FSM SHALL set COUNT to PRESET and go to CNT.
REQ-015 CNT: if Enable=0 the FSM SHALL go to IDLE with COUNT held.
  - else if COUNT>1: COUNT <= COUNT-1
  - else (COUNT 1 or 0): COUNT <= 0, state <= INT, irq_pend <= 1
REQ-016 INT, Mode 00: on the next edge Enable SHALL be cleared, the state SHALL go to IDLE, and irq_pend SHALL stay 1.
REQ-017 INT, Mode 01: on the next edge the state SHALL go to IDLE, irq_pend SHALL be cleared, and Enable SHALL be kept, so the counter reloads automatically.
REQ-018 IRQ SHALL equal irq_pend AND IM, driven from registers only.
REQ-019 Any write to CTRL or PRESET SHALL clear irq_pend, acting as the acknowledge.
REQ-020 Timing for PRESET=P≥1 with Enable written at edge N:
  - LOAD at N+1
  - COUNT=P at N+2
  - COUNT=0 and INT at N+2+P
  - auto-reload period P+3 cycles
REQ-021 PRESET=0 SHALL behave as P=1 (INT at N+3); COUNT never wraps below 0.
REQ-022 When a CTRL write and an FSM update of Enable fall on the same edge, the CTRL write SHALL win.
REQ-023 A CTRL write clearing Enable during LOAD SHALL still complete the LOAD, and the FSM SHALL then leave CNT on the following edge.
REQ-024 A PRESET write while counting SHALL not alter COUNT until the next LOAD.
REQ-025 When a set and a clear of irq_pend fall on the same edge, the clear SHALL win.

Reset
REQ-026 While reset=0, CTRL, PRESET, COUNT and irq_pend SHALL be 0 and the state SHALL be IDLE, regardless of clk.
REQ-027 After reset, Dout SHALL read 0 at every Addr and IRQ SHALL be 0.
REQ-028 Reset asserted mid-count SHALL abort the count immediately, with no IRQ.
REQ-029 After reset deasserts, the block SHALL idle until Enable is written.

Verification
REQ-030 One-shot: PRESET=5, CTRL=0x9 at edge N -> COUNT 5,4,3,2,1,0 at N+2..N+7; IRQ=1 from N+7 and held; CTRL reads 0x8 from N+8.
REQ-031 Acknowledge: from the REQ-030 end state, write CTRL=0x8 -> IRQ=0 on that edge and no restart.
REQ-032 Auto-reload: PRESET=3, CTRL=0xB -> IRQ pulses high for exactly 1 cycle every 6 cycles; COUNT reloads to 3 each period.
REQ-033 Mask: PRESET=2, CTRL=0x1 -> COUNT reaches 0 and IRQ stays 0; then CTRL=0x8 -> IRQ stays 0, because the write clears pend.
REQ-034 Edge cases: PRESET=0, CTRL=0x9 -> INT at N+3.
  - Reading Addr 3 -> Dout 0.
  - Writing Addr 2 (COUNT) -> no effect.
REQ-035 Mid-count disruption: reset=0 pulsed while COUNT=0x10 -> all registers 0, IRQ 0.
  - Separately: CTRL=0x0 written while COUNT=7 -> COUNT holds 7 and the state is IDLE.
